// File: rtl/jk_counter_n.sv
// jk_counter_n: modulo-(MAX+1) up/down counter whose state bits are each held
// in a JK cell. Supports wrap or saturate at the ends, parallel load with
// clamping, a combinational terminal-count flag and a registered wrap pulse.

// Single JK storage cell over an asynchronously cleared register.
module jk_cell (
  input  logic Clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  // JK behaviour: 00 hold, 01 clear, 10 set, 11 toggle.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= (j & ~q) | (~k & q);
  end

endmodule

module jk_counter_n #(
  parameter int WIDTH    = 4,
  parameter int MAX      = 2**WIDTH - 1,
  parameter bit SATURATE = 1'b0
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO_V = '0;

  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_end;

  // Terminal count: the next enabled step in the current direction leaves the range.
  always_comb begin
    at_end = up_dn ? (q == MAX_V) : (q == ZERO_V);
    tc     = en & ~load & at_end;
  end

  // Next-state value; load beats count, and loaded values are clamped to MAX.
  always_comb begin
    n = q;
    if (load) begin
      n = (d > MAX_V) ? MAX_V : d;
    end else if (en) begin
      if (up_dn) begin
        if (q < MAX_V) n = q + ONE_V;
        else           n = SATURATE ? MAX_V : ZERO_V;
      end else begin
        if (q > ZERO_V) n = q - ONE_V;
        else            n = SATURATE ? ZERO_V : MAX_V;
      end
    end
  end

  // Translate the desired next value into per-bit set/clear requests.
  always_comb begin
    j = n & ~q;
    k = ~n & q;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_cell u_cell (
      .Clk (Clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  // Wrap pulse: one cycle high after an edge that crossed an end in wrap mode.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) wrap <= 1'b0;
    else      wrap <= tc & ~SATURATE;
  end

endmodule

// File: tb/tb_jk_counter_n.sv
// Bench for jk_counter_n: four configurations share one stimulus stream and
// are checked every cycle against an integer model, plus literal expectations.
module tb_jk_counter_n;

  localparam int NI = 4;
  localparam int MX [NI] = '{9, 9, 15, 1};
  localparam int SAT[NI] = '{0, 1, 0, 0};
  localparam int WD [NI] = '{4, 4, 4, 1};

  logic       Clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [3:0] d = 4'd0;

  logic [3:0] q0, q1, q2;
  logic [0:0] q3;
  logic       tc0, tc1, tc2, tc3;
  logic       w0, w1, w2, w3;

  int n_cmp = 0;
  int n_bad = 0;
  int mq[NI];
  int mw[NI];

  always #5 Clk = ~Clk;

  jk_counter_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_wrap (
    .Clk(Clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(q0), .tc(tc0), .wrap(w0));
  jk_counter_n #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_sat (
    .Clk(Clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(q1), .tc(tc1), .wrap(w1));
  jk_counter_n #(.WIDTH(4), .MAX(15), .SATURATE(1'b0)) u_full (
    .Clk(Clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d),
    .q(q2), .tc(tc2), .wrap(w2));
  jk_counter_n #(.WIDTH(1), .MAX(1), .SATURATE(1'b0)) u_tgl (
    .Clk(Clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d[0:0]),
    .q(q3), .tc(tc3), .wrap(w3));

  function automatic int dut_q(int i);
    case (i)
      0: return int'(q0);
      1: return int'(q1);
      2: return int'(q2);
      default: return int'(q3);
    endcase
  endfunction

  function automatic int dut_tc(int i);
    case (i)
      0: return int'(tc0);
      1: return int'(tc1);
      2: return int'(tc2);
      default: return int'(tc3);
    endcase
  endfunction

  function automatic int dut_w(int i);
    case (i)
      0: return int'(w0);
      1: return int'(w1);
      2: return int'(w2);
      default: return int'(w3);
    endcase
  endfunction

  // Model: count value as an integer in 0..max.
  function automatic int m_next(int cur, int i);
    int dv;
    dv = int'(d) % (1 << WD[i]);
    if (load) return (dv > MX[i]) ? MX[i] : dv;
    if (!en) return cur;
    if (up_dn) return (cur < MX[i]) ? cur + 1 : (SAT[i] != 0 ? MX[i] : 0);
    return (cur > 0) ? cur - 1 : (SAT[i] != 0 ? 0 : MX[i]);
  endfunction

  function automatic int m_tc(int cur, int i);
    if (!en || load) return 0;
    if (up_dn) return (cur == MX[i]) ? 1 : 0;
    return (cur == 0) ? 1 : 0;
  endfunction

  always @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NI; i++) begin
        mq[i] <= 0;
        mw[i] <= 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        mq[i] <= m_next(mq[i], i);
        mw[i] <= (m_tc(mq[i], i) != 0 && SAT[i] == 0) ? 1 : 0;
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_loop();
    forever begin
      @(negedge Clk);
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("model_q[%0d]", i), dut_q(i), mq[i]);
        chk($sformatf("model_tc[%0d]", i), dut_tc(i), m_tc(mq[i], i));
        chk($sformatf("model_wrap[%0d]", i), dut_w(i), mw[i]);
      end
    end
  endtask

  task automatic cyc();
    @(negedge Clk);
    #1;
  endtask

  int exp_q[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
  int exp_s[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
  int sat_q[5]  = '{8, 9, 9, 9, 9};
  logic [6:0] walk[10] = '{7'b0011_101, 7'b0000_111, 7'b0000_011, 7'b0000_001,
                           7'b1111_111, 7'b1111_010, 7'b0000_010, 7'b0000_000,
                           7'b0101_100, 7'b0000_011};

  initial begin
    fork
      cmp_loop();
    join_none

    // Reset held with counting requested.
    rst = 1'b0; en = 1'b1; up_dn = 1'b1; load = 1'b0; d = 4'd0;
    #1;
    for (int c = 0; c < 2; c++) begin
      cyc();
      chk("reset_q", int'(q0), 0);
      chk("reset_wrap", int'(w0), 0);
      chk("reset_q_full", int'(q2), 0);
    end

    // Release reset, then decade wrap count for 12 edges from 0.
    rst = 1'b1;
    for (int c = 0; c < 12; c++) begin
      cyc();
      chk("decade_q", int'(q0), exp_q[c]);
      chk("decade_tc", int'(tc0), (exp_q[c] == 9) ? 1 : 0);
      chk("decade_wrap", int'(w0), (c == 9) ? 1 : 0);
      chk("decade_sat_q", int'(q1), exp_s[c]);
      chk("decade_sat_wrap", int'(w1), 0);
    end
    chk("full_q_after12", int'(q2), 12);

    // Down wrap from a loaded 1.
    load = 1'b1; d = 4'd1; en = 1'b1;
    cyc();
    chk("dn_load_q", int'(q0), 1);
    chk("dn_load_tc", int'(tc0), 0);
    load = 1'b0; up_dn = 1'b0;
    cyc();
    chk("dn_q0", int'(q0), 0);
    chk("dn_tc0", int'(tc0), 1);
    chk("dn_wrap0", int'(w0), 0);
    cyc();
    chk("dn_q9", int'(q0), 9);
    chk("dn_wrap9", int'(w0), 1);
    chk("dn_tc9", int'(tc0), 0);
    cyc();
    chk("dn_q8", int'(q0), 8);
    chk("dn_wrap8", int'(w0), 0);

    // Saturation from 7 upward, then reverse.
    load = 1'b1; d = 4'd7;
    cyc();
    chk("sat_load", int'(q1), 7);
    load = 1'b0; up_dn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cyc();
      chk("sat_q", int'(q1), sat_q[c]);
      chk("sat_tc", int'(tc1), (sat_q[c] == 9) ? 1 : 0);
      chk("sat_wrap", int'(w1), 0);
    end
    up_dn = 1'b0;
    cyc();
    chk("sat_down", int'(q1), 8);

    // Load priority and clamping.
    load = 1'b1; en = 1'b1; up_dn = 1'b1; d = 4'd4;
    cyc();
    chk("ld_q", int'(q0), 4);
    chk("ld_tc", int'(tc0), 0);
    d = 4'd14;
    cyc();
    chk("ld_clamp", int'(q0), 9);
    chk("ld_noclamp_full", int'(q2), 14);
    chk("ld_tc_at_max", int'(tc0), 0);
    cyc();
    chk("ld_wrap_none", int'(w0), 0);

    // Asynchronous reset mid-count.
    d = 4'd5;
    cyc();
    load = 1'b0;
    cyc();
    chk("async_pre_q", int'(q0), 6);
    rst = 1'b0;
    #1;
    chk("async_q", int'(q0), 0);
    chk("async_q_sat", int'(q1), 0);
    cyc();
    rst = 1'b1;
    cyc();
    chk("async_resume", int'(q0), 1);

    // Mixed directed walk: {d[3:0], load, en, up_dn}.
    for (int c = 0; c < 10; c++) begin
      {d, load, en, up_dn} = walk[c];
      cyc();
    end
    chk("toggle_sanity", int'(q3), mq[3]);

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/jk_counter_n.md
# jk_counter_n

Parametrised up/down counter built from per-bit JK flip-flop cells. Each cell is a JK stage over an asynchronously cleared D register. It is the general successor to the fixed two-bit JK state machines in this library. It supplies modulo-N counting (wrap or saturate), parallel load and terminal-count/wrap flags for use as a timer, divider or sequence counter in larger control blocks.

## Interface
- WIDTH, 4, counter width in bits (1..16)
- MAX, 2**WIDTH-1, highest count value; modulus is MAX+1 (1 <= MAX <= 2**WIDTH-1)
- SATURATE, 0, 0 = wrap at the ends; 1 = hold at the ends

- Clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-low reset
- en  input  1  count enable
- up_dn  input  1  direction: 1 = up, 0 = down
- load  input  1  synchronous parallel load, has priority over en
- d  input  WIDTH  load value
- q  output  WIDTH  current count
- tc  output  1  terminal count (combinational)
- wrap  output  1  registered one-cycle pulse after a wrap event

## Operation
- Each bit q[i] is held in a JK cell:
  - J=0, K=0 → hold
  - J=0, K=1 → clear
  - J=1, K=0 → set
  - J=1, K=1 → toggle
- The cell's storage register clears asynchronously on rst=0.
- Per-bit J/K is derived from the next-state value n: J[i] = n[i] & ~q[i], K[i] = ~n[i] & q[i].
- Next-state n, in priority order:
  - load=1: n = d; if d > MAX then n = MAX (clamped).
  - else en=0: n = q (hold).
  - else up_dn=1 and q < MAX: n = q+1.
  - else up_dn=1 and q == MAX: n = 0 if SATURATE=0, else MAX.
  - else up_dn=0 and q > 0: n = q-1.
  - else up_dn=0 and q == 0: n = MAX if SATURATE=0, else 0.
- tc = en & ~load & ((up_dn & q==MAX) | (~up_dn & q==0)). tc is asserted regardless of SATURATE.
- wrap register:
  - next value is 1 only when tc=1 and SATURATE=0;
  - next value is 0 in every other case, including load cycles.
- All arithmetic is WIDTH bits wide. q never leaves the range 0..MAX.

## Timing
- Reset:
  - rst=0 forces q=0 and wrap=0 immediately, independent of Clk.
  - tc follows q and the inputs combinationally.
  - The first counting edge is the first rising Clk with rst=1.
- Reset asserted mid-count or mid-load discards the pending update. No partial state survives.
- Latency:
  - q reflects load/count on the edge where load/en is sampled (1 cycle).
  - wrap is high for exactly the cycle following the wrapping edge.
- Simultaneous load=1 and en=1: load wins; no count, tc=0, wrap not set.
- Direction change takes effect on the next edge. No dead cycle.
- WIDTH=1, MAX=1 degenerates to a toggle flip-flop when en=1 (either direction).
- Inputs must be stable around the rising Clk edge. No internal synchronisation.

## Test plan
- Reset: hold rst=0 for 2 cycles with en=1 → q=0 and wrap=0 throughout. Release rst → q=1 on the first edge (WIDTH=4, up_dn=1).
- Decade wrap: WIDTH=4, MAX=9, SATURATE=0, en=1, up_dn=1 for 12 cycles from 0.
  - q runs 1..9, 0, 1, 2.
  - tc=1 only while q=9.
  - wrap=1 only in the cycle where q first returns to 0.
- Down wrap: MAX=9, load d=1, then en=1, up_dn=0.
  - q runs 0, 9, 8.
  - tc=1 while q=0.
  - wrap pulses once, in the cycle where q=9.
- Saturate: SATURATE=1, MAX=9, count up from 7 for 5 cycles.
  - q runs 8, 9, 9, 9, 9.
  - tc stays 1 at 9.
  - wrap stays 0.
  - Then up_dn=0 → q=8 next edge.
- Load priority/clamp: MAX=9, load=1 with en=1, d=4 → q=4, tc=0. Then load d=14 → q=9 (clamped).
- Async reset mid-count: assert rst=0 half-period after an edge with q=6 → q=0 before the next Clk edge. Count resumes from 0 after release.
